// File: rtl/stack_pkg.sv
// Shared definitions for the hardware stack: the {push,pop} operation encoding.
package stack_pkg;
  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;
endpackage

// File: rtl/stack_mem.sv
// Register array backing the stack: one synchronous write port, one combinational read port.
module stack_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents are never reset; only locations below count are ever read meaningfully.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Guards the unused address codes when DEPTH is not a power of two.
  assign rdata = (32'(raddr) < 32'(DEPTH)) ? mem_q[raddr] : '0;
endmodule

// File: rtl/hw_stack.sv
// Parametrised LIFO with registered top-of-stack, registered status flags and sticky error flags.
module hw_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int AFULL = DEPTH - 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic             clear_err,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow
);
  localparam int AW = $clog2(DEPTH);

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             afull_q, afull_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             ovf_new, unf_new;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [AW-1:0]    mem_raddr;
  logic [WIDTH-1:0] mem_rdata;

  // Entry just below the current top, which becomes the new top on a pop.
  assign mem_raddr = AW'(count_q - CW'(2));

  stack_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(din),
    .raddr(mem_raddr),
    .rdata(mem_rdata)
  );

  always_comb begin
    count_d   = count_q;
    dout_d    = dout_q;
    ovf_new   = 1'b0;
    unf_new   = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = AW'(count_q);
    case ({push, pop})
      OP_IDLE: ;
      OP_PUSH: begin
        if (!full_q) begin
          mem_we  = 1'b1;
          count_d = count_q + CW'(1);
          dout_d  = din;
        end else begin
          ovf_new = 1'b1;
        end
      end
      OP_POP: begin
        if (!empty_q) begin
          count_d = count_q - CW'(1);
          dout_d  = (count_q >= CW'(2)) ? mem_rdata : '0;
        end else begin
          unf_new = 1'b1;
        end
      end
      OP_REPL: begin
        // Replace overwrites the top in place; on an empty stack it degenerates to a push.
        mem_we = 1'b1;
        dout_d = din;
        if (empty_q) count_d = CW'(1);
        else         mem_waddr = AW'(count_q - CW'(1));
      end
      default: ;
    endcase

    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
    afull_d = (count_d >= CW'(AFULL));
    // A new error in the same cycle as clear_err leaves the flag set.
    ovf_d   = (ovf_q & ~clear_err) | ovf_new;
    unf_d   = (unf_q & ~clear_err) | unf_new;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
      dout_q  <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign dout        = dout_q;
  assign count       = count_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
endmodule

// File: tb/tb_hw_stack.sv
// Self-checking bench for hw_stack (DEPTH=4, AFULL=3) using a queue-based reference and scoreboard.
module tb_hw_stack;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AFULL = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             Reset;
  logic             push, pop, clear_err;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [CW-1:0]    count;
  logic             empty, full, almost_full, overflow, underflow;

  hw_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL(AFULL)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .push       (push),
    .pop        (pop),
    .din        (din),
    .clear_err  (clear_err),
    .dout       (dout),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .almost_full(almost_full),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] dout;
    int               count;
    logic             empty, full, afull, ovf, unf;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] stk[$];
  logic             m_ovf, m_unf;
  int               checks = 0;
  int               errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model_state();
    exp_t e;
    e.count = stk.size();
    e.dout  = (stk.size() > 0) ? stk[stk.size()-1] : '0;
    e.empty = (stk.size() == 0);
    e.full  = (stk.size() == DEPTH);
    e.afull = (stk.size() >= AFULL);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    return e;
  endfunction

  task automatic compare_outputs(input string tag, input exp_t e);
    chk({tag, ".dout"},  32'(dout),        32'(e.dout));
    chk({tag, ".count"}, 32'(count),       32'(e.count));
    chk({tag, ".empty"}, 32'(empty),       32'(e.empty));
    chk({tag, ".full"},  32'(full),        32'(e.full));
    chk({tag, ".afull"}, 32'(almost_full), 32'(e.afull));
    chk({tag, ".ovf"},   32'(overflow),    32'(e.ovf));
    chk({tag, ".unf"},   32'(underflow),   32'(e.unf));
  endtask

  // Drive one operation at the falling edge, predict its result, check just after the rising edge.
  task automatic do_op(input string tag, input logic p, input logic q,
                       input logic [WIDTH-1:0] d, input logic clr);
    logic no, nu;
    exp_t e;
    @(negedge clk);
    push = p; pop = q; din = d; clear_err = clr;
    no = 1'b0; nu = 1'b0;
    if (p && !q) begin
      if (stk.size() < DEPTH) stk.push_back(d); else no = 1'b1;
    end else if (!p && q) begin
      if (stk.size() > 0) void'(stk.pop_back()); else nu = 1'b1;
    end else if (p && q) begin
      if (stk.size() > 0) stk[stk.size()-1] = d; else stk.push_back(d);
    end
    m_ovf = (m_ovf & ~clr) | no;
    m_unf = (m_unf & ~clr) | nu;
    exp_q.push_back(model_state());
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      compare_outputs(tag, e);
    end
    push = 1'b0; pop = 1'b0; clear_err = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; push = 1'b0; pop = 1'b0; din = '0; clear_err = 1'b0;
    m_ovf = 1'b0; m_unf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compare_outputs("reset", model_state());
    @(negedge clk);
    Reset = 1'b0;

    do_op("push11", 1, 0, 8'h11, 0);
    do_op("push22", 1, 0, 8'h22, 0);
    do_op("push33", 1, 0, 8'h33, 0);
    do_op("pop1",   0, 1, 8'h00, 0);
    do_op("pop2",   0, 1, 8'h00, 0);
    do_op("pop3",   0, 1, 8'h00, 0);
    do_op("pop_underflow", 0, 1, 8'h00, 0);
    do_op("idle_sticky_unf", 0, 0, 8'h00, 0);
    do_op("clear_unf", 0, 0, 8'h00, 1);

    do_op("fill_a", 1, 0, 8'hA1, 0);
    do_op("fill_b", 1, 0, 8'hB2, 0);
    do_op("fill_c", 1, 0, 8'hC3, 0);
    do_op("fill_d", 1, 0, 8'hD4, 0);
    do_op("push_overflow", 1, 0, 8'hAA, 0);
    do_op("repl_full", 1, 1, 8'hE5, 0);
    do_op("clr_vs_new_ovf", 1, 0, 8'h99, 1);
    do_op("clear_ovf", 0, 0, 8'h00, 1);

    do_op("pop_to3", 0, 1, 8'h00, 0);
    do_op("pop_to2", 0, 1, 8'h00, 0);
    do_op("repl_5a", 1, 1, 8'h5A, 0);
    do_op("pop_after_repl", 0, 1, 8'h00, 0);
    do_op("pop_to0", 0, 1, 8'h00, 0);
    do_op("repl_empty", 1, 1, 8'h77, 0);

    do_op("pre_rst_a", 1, 0, 8'h01, 0);
    do_op("pre_rst_b", 1, 0, 8'h02, 0);
    #2;
    Reset = 1'b1;
    #1;
    stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    compare_outputs("async_reset", model_state());
    @(negedge clk);
    Reset = 1'b0;
    do_op("push_after_rst", 1, 0, 8'h3C, 0);

    for (int i = 0; i < 300; i++) begin
      do_op("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hw_stack.md
# hw_stack

Parametrised LIFO stack, the successor to the fixed 8-bit/256-entry processor stack. It adds configurable width and depth, a registered top-of-stack output, and full/empty/almost-full status. It supports simultaneous push+pop (replace-top) and sticky overflow/underflow error flags. It sits between the control unit and the datapath for call/return and operand-stack traffic.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 256, number of entries (≥2, power of 2 not required)
- AFULL, DEPTH-1, almost_full threshold on count (1..DEPTH)
- CW (derived, not overridable), $clog2(DEPTH+1), count width
- clk  in  1  clock, all state updates on rising edge
- Reset  in  1  reset, asynchronous, active-high
- push  in  1  push request, sampled at rising edge
- pop  in  1  pop request, sampled at rising edge
- din  in  WIDTH  data for push/replace
- clear_err  in  1  clears sticky overflow/underflow
- dout  out  WIDTH  registered top-of-stack value; 0 when empty
- count  out  CW  number of valid entries, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_full  out  1  count ≥ AFULL
- overflow  out  1  sticky: push attempted while full
- underflow  out  1  sticky: pop attempted while empty

## Operation
- Storage: DEPTH×WIDTH array; entry i holds the i-th pushed item still present (0 = bottom). The array is not reset.
- Per cycle, with {push,pop} sampled:
  - 00 idle: no state change.
  - 10 push, !full: mem[count]←din, count+1, dout←din.
  - 10 push, full: array, count and dout unchanged; overflow←1.
  - 01 pop, !empty: count−1; dout←mem[count−2] if count≥2, else 0.
  - 01 pop, empty: no change; underflow←1.
  - 11 replace, !empty: mem[count−1]←din, dout←din, count unchanged. Never sets overflow, including when full.
  - 11 replace, empty: behaves as push (count 0→1, dout←din). No underflow.
- Flags: empty, full and almost_full are registered and updated in the same edge as count. They never disagree with count.
- Errors: overflow/underflow stay set until clear_err. If clear_err and a new error occur in the same cycle, the error wins and the flag ends at 1.
- Count arithmetic is CW-bit unsigned and never wraps. Out-of-range push/pop are rejected as above.

## Timing
- Reset values: dout=0, count=0, empty=1, full=0, almost_full=(AFULL==0? n/a → 0), overflow=0, underflow=0.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously). An operation sampled on the same edge as reset release is ignored.
- Latency: one cycle. Outputs reflect an operation sampled at edge N from just after edge N.
- The pushed value is visible on dout one cycle later. The value below the top is visible one cycle after a pop.
- Back-to-back operations are supported every cycle with no bubbles. There is no handshake stall: push and pop are always accepted or rejected the same cycle.
- Internal array read is combinational from the register array. There is no read-latency cycle.

## Structure
- Package stack_pkg holds the op encoding constants OP_IDLE=2'b00, OP_POP=2'b01, OP_PUSH=2'b10, OP_REPL=2'b11, used in the {push,pop} case decode.
- Sub-module stack_mem: DEPTH×WIDTH register array with one synchronous write port (we, waddr, wdata) and one combinational read port (raddr, rdata). hw_stack owns count, dout, flags and errors.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles → dout 0x11, 0x22, 0x33; count 1, 2, 3; empty 0 after the first push.
- From count=3 (top 0x33), pop ×3 → dout 0x22, 0x11, 0x00; count 2, 1, 0; empty=1 at the end. A 4th pop → underflow=1, count stays 0.
- DEPTH=4: push 4 items → full=1, almost_full=1 (AFULL=3) from count=3. A 5th push 0xAA → overflow=1, dout and count unchanged. Then assert clear_err → overflow=0.
- Count=2, top 0x22: push=pop=1, din=0x5A → dout=0x5A, count=2. Then pop → dout=old entry 0 value.
- Empty stack, push=pop=1 with din=0x77 → count=1, dout=0x77, underflow=0.
- Count=3: assert Reset between edges → count=0, dout=0, flags at reset values immediately. A push on the first edge after release is accepted normally.
